// File: rtl/top_memoria_pkg.sv
// Shared definitions for the MEM stage: access-size selector encodings and
// the clogb2 helper used to size register-index ports.
package top_memoria_pkg;

  // Low two selector bits give the access size; bit 2 marks an unsigned load.
  localparam logic [1:0] SEL_BYTE = 2'b01;
  localparam logic [1:0] SEL_HALF = 2'b10;
  localparam logic [1:0] SEL_WORD = 2'b11;
  localparam int SEL_UNSIGNED_BIT = 2;

  // Number of bits needed to represent value (clogb2(31) = 5).
  function automatic int clogb2(input int value);
    int n;
    n = 0;
    for (int v = value; v > 0; v = v >> 1) n++;
    return n;
  endfunction

endpackage

// File: rtl/top_memoria_datos.sv
// Simple dual-port data memory. Port A is read/write with byte enables and a
// read-first, enable-gated output register; port B is a read-only debug port.
// Only the output registers are reset; the array contents survive reset.
module memoria_datos #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_a,
  input  logic [DATA_W/8-1:0]   we_a,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic [DATA_W-1:0]     din_a,
  output logic [DATA_W-1:0]     dout_a,
  input  logic                  en_b,
  input  logic [ADDR_W-1:0]     addr_b,
  output logic [DATA_W-1:0]     dout_b
);

  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes on port A.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we_a[i]) mem[addr_a][i*8 +: 8] <= din_a[i*8 +: 8];
    end
  end

  // Port A read-first output register, held while the pipeline stalls.
  always_ff @(posedge clk) begin
    if (rst) dout_a <= '0;
    else if (en_a) dout_a <= mem[addr_a];
  end

  // Port B read-only output register, updated only on a serviced request.
  always_ff @(posedge clk) begin
    if (rst) dout_b <= '0;
    else if (en_b) dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/top_memoria.sv
// MEM stage: data-memory loads/stores with size selection and extension,
// MEM/WB pipeline register, sticky halt flag and a stall-time debug read port.
module top_memoria
  import top_memoria_pkg::*;
#(
  parameter int WIDTH_DATA_MEM = 32,
  parameter int CANT_REGISTROS = 32,
  parameter int CANT_BITS_ADDR_DATOS = 10,
  parameter int CANT_BITS_SELECT_BYTES_MEM_DATA = 3,
  localparam int REG_W = clogb2(CANT_REGISTROS - 1)
) (
  input  logic                                       i_clock,
  input  logic                                       i_soft_reset,
  input  logic                                       i_enable_pipeline,
  input  logic [WIDTH_DATA_MEM-1:0]                  i_result,
  input  logic [WIDTH_DATA_MEM-1:0]                  i_data_write_to_mem,
  input  logic [REG_W-1:0]                           i_registro_destino,
  input  logic                                       i_RegWrite,
  input  logic                                       i_MemRead,
  input  logic                                       i_MemWrite,
  input  logic                                       i_MemtoReg,
  input  logic                                       i_halt_detected,
  input  logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] i_select_bytes_mem_datos,
  input  logic                                       i_debug_read_enable,
  input  logic [CANT_BITS_ADDR_DATOS-1:0]            i_debug_addr,
  output logic                                       o_RegWrite,
  output logic                                       o_MemtoReg,
  output logic                                       o_halt_detected,
  output logic [WIDTH_DATA_MEM-1:0]                  o_read_data,
  output logic [WIDTH_DATA_MEM-1:0]                  o_alu_result,
  output logic [REG_W-1:0]                           o_registro_destino,
  output logic [WIDTH_DATA_MEM-1:0]                  o_data_forward_MEM,
  output logic [WIDTH_DATA_MEM-1:0]                  o_debug_data,
  output logic                                       o_debug_valid
);

  // Lane extraction plus sign/zero extension of a loaded word.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [2:0]  sel,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic        uns;
    logic [31:0] res;
    b   = word[{off, 3'b000} +: 8];
    h   = word[{off[1], 4'b0000} +: 16];
    uns = sel[SEL_UNSIGNED_BIT];
    case (sel[1:0])
      SEL_BYTE: res = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SEL_HALF: res = uns ? {16'b0, h} : {{16{h[15]}}, h};
      SEL_WORD: res = word;
      default:  res = word;
    endcase
    return res;
  endfunction

  logic [1:0]                           off;
  logic [CANT_BITS_ADDR_DATOS-1:0]      word_idx;
  logic [3:0]                           byte_en;
  logic [3:0]                           we;
  logic [WIDTH_DATA_MEM-1:0]            store_data;
  logic [WIDTH_DATA_MEM-1:0]            mem_rd;
  logic                                 halt;
  logic                                 store_ok;
  logic                                 dbg_en;

  logic                                 rw_p1;
  logic                                 m2r_p1;
  logic [WIDTH_DATA_MEM-1:0]            alu_p1;
  logic [REG_W-1:0]                     rd_p1;
  logic [2:0]                           sel_p1;
  logic [1:0]                           off_p1;
  logic                                 vld_p1;

  // Upper address bits are dropped, so accesses wrap modulo 4 KiB.
  assign off      = i_result[1:0];
  assign word_idx = i_result[CANT_BITS_ADDR_DATOS+1:2];

  // Byte enables and lane-replicated store data from size and offset.
  always_comb begin
    byte_en    = 4'b1111;
    store_data = i_data_write_to_mem;
    case (i_select_bytes_mem_datos[1:0])
      SEL_BYTE: begin
        byte_en    = 4'b0001 << off;
        store_data = {4{i_data_write_to_mem[7:0]}};
      end
      SEL_HALF: begin
        byte_en    = off[1] ? 4'b1100 : 4'b0011;
        store_data = {2{i_data_write_to_mem[15:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        store_data = i_data_write_to_mem;
      end
    endcase
  end

  assign store_ok = i_MemWrite & i_enable_pipeline & ~i_soft_reset & ~halt;
  assign we       = store_ok ? byte_en : 4'b0000;
  assign dbg_en   = i_debug_read_enable & ~i_enable_pipeline;

  memoria_datos #(
    .DATA_W (WIDTH_DATA_MEM),
    .ADDR_W (CANT_BITS_ADDR_DATOS)
  ) u_mem (
    .clk    (i_clock),
    .rst    (i_soft_reset),
    .en_a   (i_enable_pipeline),
    .we_a   (we),
    .addr_a (word_idx),
    .din_a  (store_data),
    .dout_a (mem_rd),
    .en_b   (dbg_en),
    .addr_b (i_debug_addr),
    .dout_b (o_debug_data)
  );

  // ---- EX/MEM -> MEM/WB boundary (p1) ----
  // MEM/WB register and the offset/selector that travel with the port-A read.
  always_ff @(posedge i_clock) begin
    if (i_soft_reset) begin
      rw_p1  <= 1'b0;
      m2r_p1 <= 1'b0;
      alu_p1 <= '0;
      rd_p1  <= '0;
      sel_p1 <= '0;
      off_p1 <= '0;
    end else if (i_enable_pipeline) begin
      rw_p1  <= i_RegWrite;
      m2r_p1 <= i_MemtoReg;
      alu_p1 <= i_result;
      rd_p1  <= i_registro_destino;
      sel_p1 <= i_select_bytes_mem_datos[2:0];
      off_p1 <= off;
    end
  end

  // Sticky halt flag: set on an enabled cycle, cleared only by reset.
  always_ff @(posedge i_clock) begin
    if (i_soft_reset) halt <= 1'b0;
    else if (i_enable_pipeline && i_halt_detected) halt <= 1'b1;
  end

  // Debug response valid: one-cycle pulse after a serviced request.
  always_ff @(posedge i_clock) begin
    if (i_soft_reset) vld_p1 <= 1'b0;
    else vld_p1 <= dbg_en;
  end

  assign o_RegWrite         = rw_p1 & ~halt;
  assign o_MemtoReg         = m2r_p1;
  assign o_halt_detected    = halt;
  assign o_alu_result       = alu_p1;
  assign o_registro_destino = rd_p1;
  assign o_read_data        = extend_load(mem_rd, sel_p1, off_p1);
  assign o_data_forward_MEM = i_result;
  assign o_debug_valid      = vld_p1;

endmodule

// File: tb/tb_top_memoria.sv
// Bench for the MEM stage: directed vector table, stall/debug/reset/halt
// sequences, and randomized traffic against a byte-array reference model.
module tb_top_memoria;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] result;
  logic [31:0] wdata;
  logic [4:0]  rd_in;
  logic        rw_in, mr_in, mw_in, m2r_in, halt_in;
  logic [2:0]  sel_in;
  logic        dbg_en;
  logic [9:0]  dbg_addr;

  logic        rw_out, m2r_out, halt_out;
  logic [31:0] read_data, alu_out, fwd, dbg_data;
  logic [4:0]  rd_out;
  logic        dbg_valid;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  top_memoria dut (
    .i_clock                  (clk),
    .i_soft_reset             (rst),
    .i_enable_pipeline        (en),
    .i_result                 (result),
    .i_data_write_to_mem      (wdata),
    .i_registro_destino       (rd_in),
    .i_RegWrite               (rw_in),
    .i_MemRead                (mr_in),
    .i_MemWrite               (mw_in),
    .i_MemtoReg               (m2r_in),
    .i_halt_detected          (halt_in),
    .i_select_bytes_mem_datos (sel_in),
    .i_debug_read_enable      (dbg_en),
    .i_debug_addr             (dbg_addr),
    .o_RegWrite               (rw_out),
    .o_MemtoReg               (m2r_out),
    .o_halt_detected          (halt_out),
    .o_read_data              (read_data),
    .o_alu_result             (alu_out),
    .o_registro_destino       (rd_out),
    .o_data_forward_MEM       (fwd),
    .o_debug_data             (dbg_data),
    .o_debug_valid            (dbg_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference model: memory as a flat array of bytes, byte address = addr mod 4096.
  logic [7:0] mm [4096];

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] sel);
    int a, h, w;
    logic [31:0] r;
    a = int'(addr[11:0]);
    h = a & ~1;
    w = a & ~3;
    case (sel)
      3'b001:  r = {{24{mm[a][7]}}, mm[a]};
      3'b101:  r = {24'b0, mm[a]};
      3'b010:  r = {{16{mm[h+1][7]}}, mm[h+1], mm[h]};
      3'b110:  r = {16'b0, mm[h+1], mm[h]};
      default: r = {mm[w+3], mm[w+2], mm[w+1], mm[w]};
    endcase
    return r;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] d, input logic [2:0] sel);
    int a, h, w;
    a = int'(addr[11:0]);
    h = a & ~1;
    w = a & ~3;
    case (sel[1:0])
      2'b01: mm[a] = d[7:0];
      2'b10: begin
        mm[h]   = d[7:0];
        mm[h+1] = d[15:8];
      end
      default: begin
        mm[w]   = d[7:0];
        mm[w+1] = d[15:8];
        mm[w+2] = d[23:16];
        mm[w+3] = d[31:24];
      end
    endcase
  endtask

  logic [31:0] exp_read, exp_alu;
  logic [4:0]  exp_rd;
  logic        exp_rw, exp_m2r;

  task automatic model_cycle(input logic e, input logic mw, input logic [31:0] addr,
                             input logic [31:0] d, input logic [2:0] sel, input logic rw,
                             input logic m2r, input logic [4:0] rd, input bit do_chk);
    en = e; mw_in = mw; mr_in = ~mw; result = addr; wdata = d; sel_in = sel;
    rw_in = rw; m2r_in = m2r; rd_in = rd; halt_in = 1'b0; dbg_en = 1'b0;
    if (e) begin
      exp_read = model_load(addr, sel);
      exp_alu  = addr;
      exp_rd   = rd;
      exp_rw   = rw;
      exp_m2r  = m2r;
      if (mw) model_store(addr, d, sel);
    end
    #1;
    if (do_chk) chk("rand_forward", fwd, addr);
    step;
    if (do_chk) begin
      chk("rand_read_data", read_data, exp_read);
      chk("rand_alu", alu_out, exp_alu);
      chk("rand_rd", {27'b0, rd_out}, {27'b0, exp_rd});
      chk("rand_regwrite", {31'b0, rw_out}, {31'b0, exp_rw});
      chk("rand_memtoreg", {31'b0, m2r_out}, {31'b0, exp_m2r});
      chk("rand_halt", {31'b0, halt_out}, 32'd0);
      chk("rand_dbg_valid", {31'b0, dbg_valid}, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_read_data"}, read_data, 32'd0);
    chk({tag, "_alu"}, alu_out, 32'd0);
    chk({tag, "_rd"}, {27'b0, rd_out}, 32'd0);
    chk({tag, "_regwrite"}, {31'b0, rw_out}, 32'd0);
    chk({tag, "_memtoreg"}, {31'b0, m2r_out}, 32'd0);
    chk({tag, "_halt"}, {31'b0, halt_out}, 32'd0);
    chk({tag, "_dbg_valid"}, {31'b0, dbg_valid}, 32'd0);
    chk({tag, "_dbg_data"}, dbg_data, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] d;
    logic [2:0]  sel;
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic        do_chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 3'b011, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,   32'h0,        3'b011, 1'b1, 1'b1, 5'd7, 1'b1, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h11,   32'h00000080, 3'b001, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h11,   32'h0,        3'b001, 1'b1, 1'b1, 5'd3, 1'b1, 32'hFFFFFF80};
    tbl[4]  = '{1'b0, 32'h11,   32'h0,        3'b101, 1'b1, 1'b0, 5'd4, 1'b1, 32'h00000080};
    tbl[5]  = '{1'b0, 32'h10,   32'h0,        3'b011, 1'b1, 1'b1, 5'd6, 1'b1, 32'hDEAD80EF};
    tbl[6]  = '{1'b0, 32'h12,   32'h0,        3'b010, 1'b1, 1'b1, 5'd8, 1'b1, 32'hFFFFDEAD};
    tbl[7]  = '{1'b0, 32'h12,   32'h0,        3'b110, 1'b0, 1'b1, 5'd9, 1'b1, 32'h0000DEAD};
    tbl[8]  = '{1'b0, 32'h13,   32'h0,        3'b010, 1'b1, 1'b0, 5'd10, 1'b1, 32'hFFFFDEAD};
    tbl[9]  = '{1'b0, 32'h10,   32'h0,        3'b000, 1'b1, 1'b1, 5'd11, 1'b1, 32'hDEAD80EF};
    tbl[10] = '{1'b0, 32'h1010, 32'h0,        3'b011, 1'b1, 1'b1, 5'd5, 1'b1, 32'hDEAD80EF};

    rst = 1'b1; en = 1'b0; result = '0; wdata = '0; rd_in = '0;
    rw_in = 1'b0; mr_in = 1'b0; mw_in = 1'b0; m2r_in = 1'b0; halt_in = 1'b0;
    sel_in = 3'b011; dbg_en = 1'b0; dbg_addr = '0;
    step;
    step;
    check_all_zero("reset");
    rst = 1'b0;

    // Known word at 0x20 for the reset-with-store sequence.
    en = 1'b1; mw_in = 1'b1; result = 32'h20; wdata = 32'hCAFEF00D; sel_in = 3'b011;
    step;

    for (int i = 0; i < 11; i++) begin
      en = 1'b1; mw_in = tbl[i].we; mr_in = ~tbl[i].we; result = tbl[i].addr;
      wdata = tbl[i].d; sel_in = tbl[i].sel; rw_in = tbl[i].rw; m2r_in = tbl[i].m2r;
      rd_in = tbl[i].rd;
      #1;
      chk("vec_forward", fwd, tbl[i].addr);
      step;
      if (tbl[i].do_chk) begin
        chk("vec_read_data", read_data, tbl[i].exp);
        chk("vec_alu", alu_out, tbl[i].addr);
        chk("vec_rd", {27'b0, rd_out}, {27'b0, tbl[i].rd});
        chk("vec_memtoreg", {31'b0, m2r_out}, {31'b0, tbl[i].m2r});
        chk("vec_regwrite", {31'b0, rw_out}, {31'b0, tbl[i].rw});
      end
    end

    // Stall with a store pending: nothing written, MEM/WB held.
    en = 1'b0; mw_in = 1'b1; mr_in = 1'b0; result = 32'h10; wdata = 32'h11111111;
    sel_in = 3'b001; rd_in = 5'd20; rw_in = 1'b0; m2r_in = 1'b0;
    step;
    step;
    chk("stall_read_data", read_data, 32'hDEAD80EF);
    chk("stall_alu", alu_out, 32'h1010);
    chk("stall_rd", {27'b0, rd_out}, 32'd5);
    chk("stall_regwrite", {31'b0, rw_out}, 32'd1);
    chk("stall_memtoreg", {31'b0, m2r_out}, 32'd1);

    dbg_en = 1'b1; dbg_addr = 10'd4;
    step;
    chk("dbg_valid_pulse", {31'b0, dbg_valid}, 32'd1);
    chk("dbg_data", dbg_data, 32'hDEAD80EF);
    dbg_en = 1'b0;
    step;
    chk("dbg_valid_drop", {31'b0, dbg_valid}, 32'd0);
    chk("dbg_data_hold", dbg_data, 32'hDEAD80EF);

    dbg_en = 1'b1; dbg_addr = 10'd8;
    step;
    chk("dbg_word8_valid", {31'b0, dbg_valid}, 32'd1);
    chk("dbg_word8_data", dbg_data, 32'hCAFEF00D);
    dbg_addr = 10'd4;
    step;
    dbg_en = 1'b0;
    step;

    // Request while enabled is dropped; memory unchanged by the stalled store.
    en = 1'b1; mw_in = 1'b0; mr_in = 1'b1; result = 32'h10; sel_in = 3'b011;
    dbg_en = 1'b1; dbg_addr = 10'd8;
    step;
    dbg_en = 1'b0;
    chk("dbg_enabled_valid", {31'b0, dbg_valid}, 32'd0);
    chk("dbg_enabled_data", dbg_data, 32'hDEAD80EF);
    chk("stall_no_write", read_data, 32'hDEAD80EF);
    step;
    chk("dbg_enabled_valid_late", {31'b0, dbg_valid}, 32'd0);

    // Reset in the same cycle as a store: outputs cleared, store dropped.
    rst = 1'b1; en = 1'b1; mw_in = 1'b1; mr_in = 1'b0; result = 32'h20;
    wdata = 32'h12345678; sel_in = 3'b011; rw_in = 1'b1; m2r_in = 1'b1; rd_in = 5'd12;
    step;
    check_all_zero("rst_store");
    rst = 1'b0; mw_in = 1'b0; mr_in = 1'b1;
    step;
    chk("rst_store_dropped", read_data, 32'hCAFEF00D);

    // Randomized traffic against the byte-array model.
    rst = 1'b1; step; rst = 1'b0;
    exp_read = '0; exp_alu = '0; exp_rd = '0; exp_rw = 1'b0; exp_m2r = 1'b0;
    for (int i = 0; i < 64; i++) begin
      r = $urandom;
      model_cycle(1'b1, 1'b1, 32'(i * 4), r, 3'b011, 1'b0, 1'b0, 5'd0, 1'b0);
    end
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ar, dr;
      logic [2:0]  sr;
      logic [4:0]  rr;
      ar = $urandom;
      dr = $urandom;
      sr = 3'($urandom_range(0, 7));
      rr = 5'($urandom_range(0, 31));
      model_cycle($urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                  {ar[31:12], 4'h0, ar[7:0]}, dr, sr,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rr, 1'b1);
    end

    // Halt: flag sticks, RegWrite forced low, stores suppressed.
    en = 1'b1; halt_in = 1'b1; mw_in = 1'b0; mr_in = 1'b1; result = 32'h0;
    sel_in = 3'b011; rw_in = 1'b1;
    step;
    halt_in = 1'b0;
    chk("halt_set", {31'b0, halt_out}, 32'd1);
    chk("halt_regwrite", {31'b0, rw_out}, 32'd0);
    mw_in = 1'b1; mr_in = 1'b0; wdata = 32'h55555555;
    step;
    chk("halt_sticky", {31'b0, halt_out}, 32'd1);
    chk("halt_regwrite2", {31'b0, rw_out}, 32'd0);
    mw_in = 1'b0; mr_in = 1'b1;
    step;
    chk("halt_store_blocked", read_data, model_load(32'h0, 3'b011));
    en = 1'b0;
    step;
    chk("halt_stall_hold", {31'b0, halt_out}, 32'd1);
    rst = 1'b1; en = 1'b1;
    step;
    chk("halt_cleared", {31'b0, halt_out}, 32'd0);
    rst = 1'b0;
    step;
    chk("post_halt_regwrite", {31'b0, rw_out}, 32'd1);
    chk("post_halt_read", read_data, model_load(32'h0, 3'b011));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
